// File: rtl/rotl_serial.sv
// rotl_serial: multi-cycle rotate-left unit.
// Inverts the fixed rotate-right wiring of the hash datapath for debug
// readback and gives variable-amount rotation without a full barrel
// shifter. Up to STEP bit positions are rotated per clock until the
// requested amount is consumed. One request is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   unit can accept a request (high only in IDLE)
//   in_data    word to rotate, sampled only at the accept edge
//   in_amt     rotate-left amount 0..WIDTH-1, sampled only at the accept edge
//   out_valid  result present (DONE)
//   out_ready  consumer accepts result
//   out_data   rotated word, registered, stable while out_valid && !out_ready
//   busy       state is not IDLE
module rotl_serial #(
    parameter int   WIDTH = 32,
    parameter int   STEP  = 4,
    localparam int  AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // One extra bit so that STEP == WIDTH is representable.
    localparam int          AWP     = AW + 1;
    localparam logic [AW:0] STEP_K  = AWP'(STEP);
    localparam logic [AW:0] WIDTH_K = AWP'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    rem_q, rem_d;

    logic [AW:0]      k;
    logic [AW:0]      k_comp;
    logic [WIDTH-1:0] rot;
    logic [AW-1:0]    rem_after;

    // Per-cycle amount k = min(remaining, STEP). The rotate is only used
    // in ROT where remaining > 0, so k is never 0 there and the right
    // shift by WIDTH-k stays below WIDTH.
    always_comb begin
        if ({1'b0, rem_q} < STEP_K) begin
            k = {1'b0, rem_q};
        end else begin
            k = STEP_K;
        end
        k_comp    = WIDTH_K - k;
        rot       = (data_q << k) | (data_q >> k_comp);
        rem_after = rem_q - k[AW-1:0];
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = in_amt;
                    state_d = (in_amt == '0) ? DONE : ROT;
                end
            end
            ROT: begin
                data_d = rot;
                rem_d  = rem_after;
                if (rem_after == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    // Handshake outputs decode the state register only; out_ready never
    // reaches in_ready within the same cycle.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_rotl_serial.sv
// Directed bench for rotl_serial. Three instances (STEP = 1, 4, 32) share
// the request and out_ready lines; each request is accepted by all three
// on the same edge and their results and latencies are checked separately.
module tb_rotl_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        out_ready;

    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  busy_v;
    logic [31:0] out_data_v [3];

    int checks = 0;
    int errors = 0;
    int steps [3] = '{1, 4, 32};

    always #5 clk = ~clk;

    rotl_serial #(.WIDTH(32), .STEP(1)) u_step1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_data(out_data_v[0]), .busy(busy_v[0])
    );

    rotl_serial #(.WIDTH(32), .STEP(4)) u_step4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_data(out_data_v[1]), .busy(busy_v[1])
    );

    rotl_serial #(.WIDTH(32), .STEP(32)) u_step32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_data(out_data_v[2]), .busy(busy_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Edges after the accepting edge until out_valid is seen; an amount of
    // 0 is visible directly after the accepting edge.
    function automatic int exp_lat(input int amt, input int step);
        if (amt == 0) return 0;
        return (amt + step - 1) / step;
    endfunction

    task automatic check_idle_all(input string tag);
        check({tag, "_rdy"},  {29'b0, in_ready_v},  32'h7);
        check({tag, "_oval"}, {29'b0, out_valid_v}, 32'h0);
        check({tag, "_busy"}, {29'b0, busy_v},      32'h0);
    endtask

    // One request through all three instances. hold = cycles of
    // backpressure applied once every instance shows its result.
    task automatic run_req(input string tag, input logic [31:0] d,
                           input logic [4:0] a, input logic [31:0] e,
                           input int hold);
        int  lat  [3];
        bit  seen [3];
        bit  all_seen;
        @(negedge clk);
        check({tag, "_pre_rdy"}, {29'b0, in_ready_v}, 32'h7);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        @(posedge clk);
        #1;
        // in_valid stays up with different data: must be ignored while busy.
        in_data = ~d;
        in_amt  = a + 5'd7;
        for (int i = 0; i < 3; i++) begin
            seen[i] = 1'b0;
            lat[i]  = 99;
        end
        for (int n = 0; n <= 40; n++) begin
            all_seen = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && out_valid_v[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = n;
                end
                if (!seen[i]) all_seen = 1'b0;
            end
            if (all_seen) break;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_lat_s%0d", tag, steps[i]), lat[i], exp_lat(int'(a), steps[i]));
            check($sformatf("%s_data_s%0d", tag, steps[i]), out_data_v[i], e);
        end
        check({tag, "_busy"}, {29'b0, busy_v}, 32'h7);
        check({tag, "_rdy_busy"}, {29'b0, in_ready_v}, 32'h0);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_bp%0d_data", tag, c), out_data_v[1], e);
            check($sformatf("%s_bp%0d_oval", tag, c), {29'b0, out_valid_v}, 32'h7);
            check($sformatf("%s_bp%0d_rdy", tag, c), {29'b0, in_ready_v}, 32'h0);
            check($sformatf("%s_bp%0d_busy", tag, c), {29'b0, busy_v}, 32'h7);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_idle_all({tag, "_post"});
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle, checked before the next edge.
        #13 rst_n = 1'b0;
        #1;
        check_idle_all("reset");
        check("reset_data", out_data_v[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req("inv17",  32'h2B3C091A, 5'd17, 32'h12345678, 0);
        run_req("amt0",   32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0);
        run_req("amt1",   32'h80000001, 5'd1,  32'h00000003, 0);
        run_req("amt4",   32'h12345678, 5'd4,  32'h23456781, 0);
        run_req("amt5",   32'hF0000000, 5'd5,  32'h0000001E, 0);
        run_req("amt3",   32'h00000001, 5'd3,  32'h00000008, 0);
        run_req("amt16",  32'hA5A5A5A5, 5'd16, 32'hA5A5A5A5, 0);
        run_req("amt2",   32'hC0000000, 5'd2,  32'h00000003, 0);
        run_req("bp8",    32'h12345678, 5'd8,  32'h34567812, 10);

        // Reset mid-operation: STEP=32 instance already in DONE, others in ROT.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h00000001;
        in_amt   = 5'd31;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_pre_oval", {29'b0, out_valid_v}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check_idle_all("mid_rst");
        check("mid_rst_data", out_data_v[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("mid_after%0d_oval", c), {29'b0, out_valid_v}, 32'h0);
        end

        run_req("amt31",  32'h00000001, 5'd31, 32'h80000000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
